mux32_readout_sched: RTL and testbench
======================================

# mux32_readout_sched

Scheduler that drives the select of the 32-to-1 result mux in the low-power systolic array and streams the selected 17-bit lane results out over a valid/ready interface. On `start` it snapshots a lane mask and visits only the enabled lanes, lowest index first. It emits one result per cycle when downstream is ready, and holds the mux select constant while idle or stalled to avoid mux toggling. It sits between the array's result mux and the result writeback/output logic.

## Interface
- `DATA_W`, 17, width of each lane result
- `LANES`, 32, number of mux inputs
- `SEL_W`, 8, width of the mux select port; upper bits above 5 are driven 0

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a readout pass; sampled only in IDLE
- `lane_mask`  in  LANES  lanes to read; sampled with `start`
- `sel`  out  SEL_W  select to mux32to1
- `mux_y`  in  DATA_W  combinational mux output for the current `sel`
- `out_data`  out  DATA_W  captured lane result
- `out_lane`  out  5  lane index of `out_data`
- `out_last`  out  1  marks the final beat of the pass
- `out_valid`  out  1  beat available
- `out_ready`  in  1  downstream accepts the beat
- `busy`  out  1  high in SCAN and DRAIN
- `done`  out  1  one-cycle pulse at end of pass

## Operation
- States:
  - IDLE
  - SCAN: pending lanes remain to capture.
  - DRAIN: last beat is captured and waiting for handshake.
- IDLE, `start`=1:
  - Latch `pend` = `lane_mask`.
  - If `pend`≠0: `sel` ← lowest set index, go to SCAN.
  - If `pend`=0: `done` pulses next cycle, stay in IDLE, no beats.
- SCAN: the output slot is free when `!out_valid || out_ready`. Each cycle the slot is free:
  - Capture `out_data` ← `mux_y`, `out_lane` ← `sel[4:0]`, `out_valid` ← 1.
  - Clear bit `sel` in `pend`.
  - If other pending bits remain: `sel` ← lowest remaining set index, `out_last` ← 0.
  - Otherwise: `out_last` ← 1, `sel` unchanged, go to DRAIN.
- SCAN, slot not free: `sel`, `pend`, and the output registers hold.
- DRAIN:
  - On `out_valid && out_ready`: clear `out_valid` and `out_last`, pulse `done` for 1 cycle, go to IDLE.
  - Otherwise hold.
- `start` in SCAN or DRAIN is ignored; `lane_mask` changes after sampling have no effect.
- `sel` is never changed in IDLE. It holds its last value for low mux switching activity.
- Output registers hold their values while `out_valid`=1 and `out_ready`=0. Data must not change under a stall.

## Timing
- Reset values:
  - state IDLE
  - `sel`=0, `pend`=0
  - `out_data`=0, `out_lane`=0
  - `out_valid`=0, `out_last`=0
  - `busy`=0, `done`=0
- Reset asserted mid-pass aborts the pass immediately. The next cycle shows reset values; no `done` pulse is produced.
- Latency with `start` sampled at edge 0:
  - `sel` = first lane after edge 0.
  - First `out_valid` after edge 1.
- Throughput: 1 beat/cycle with `out_ready` held high. A mask with N set bits produces N beats on consecutive cycles.
- With `out_ready`=1 throughout, `done` asserts one cycle after the last beat's handshake.
- Single-lane mask: a single beat is produced with `out_last`=1.
- Lane 31 is the highest index; there is no wrap-around within a pass.
- `busy` is registered and is high from the cycle after `start` until `done`.

## Structure
- Package `sysarr_pkg`:
  - Constants `LANES`=32, `DATA_W`=17, `SEL_W`=8, `LANE_W`=5.
  - State typedef {IDLE, SCAN, DRAIN}.
- Sub-module `lane_pick_first`: combinational priority encoder over `LANES` bits. Outputs `idx[4:0]` (lowest set bit) and `any`. It is used for both the first-lane and next-lane selection, with the next lane computed as pick-first of `pend & ~onehot(sel)`.
- Target size: about 150–250 lines of RTL.

## Test plan
- Mask 32'hFFFF_FFFF, `out_ready`=1, `mux_y` = lane index + 100:
  - 32 beats on consecutive cycles, `out_lane` 0..31, `out_data` 100..131.
  - `out_last` only on lane 31; `done` one cycle after.
- Mask 32'h8000_0011:
  - Beats on lanes 0, 4, 31 only; `out_last` on lane 31.
  - `sel` never takes a masked value.
- Mask 0:
  - `done` pulses 1 cycle after `start`, `out_valid` never rises, `busy` stays 0.
- Mask 32'h0000_000F with `out_ready` low for 3 cycles on the lane-1 beat:
  - `out_data`, `out_lane`, and `sel` hold stable during the stall.
  - Lanes 2 and 3 follow afterward; no beat is lost or duplicated.
- Reset asserted while lane 5 of 32'h0000_00FF is pending:
  - All outputs at reset values next cycle, no `done`.
  - A new `start` with mask 32'h1 yields a single beat on lane 0 with `out_last`=1.
- `start` pulsed again mid-pass with a different mask:
  - Ignored; the beat sequence matches the original mask exactly.

Source files
------------

// File: rtl/sysarr_pkg.sv
// Shared constants and types for the systolic-array result readout path.
package sysarr_pkg;

  localparam int LANES  = 32;
  localparam int DATA_W = 17;
  localparam int SEL_W  = 8;
  localparam int LANE_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mux32_readout_sched_if.sv
// Bundle of the mux-select, lane-result and valid/ready beat signals.
// The master side is the scheduler; the slave side is the array mux plus
// the downstream consumer.
interface mux32_readout_sched_if;
  import sysarr_pkg::*;

  logic                start;
  logic [LANES-1:0]    lane_mask;
  logic [SEL_W-1:0]    sel;
  logic [DATA_W-1:0]   mux_y;
  logic [DATA_W-1:0]   out_data;
  logic [LANE_W-1:0]   out_lane;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;

  modport master (
    input  start, lane_mask, mux_y, out_ready,
    output sel, out_data, out_lane, out_last, out_valid, busy, done
  );

  modport slave (
    output start, lane_mask, mux_y, out_ready,
    input  sel, out_data, out_lane, out_last, out_valid, busy, done
  );

endinterface

// File: rtl/lane_pick_first.sv
// Priority encoder: index of the lowest set bit of a lane vector.
module lane_pick_first
  import sysarr_pkg::*;
(
  input  logic [LANES-1:0]  vec,
  output logic [LANE_W-1:0] idx,
  output logic              any
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx = '0;
    any = |vec;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (vec[i]) idx = LANE_W'(i);
    end
  end

endmodule

// File: rtl/mux32_readout_sched.sv
// Readout scheduler: walks the enabled lanes of a snapshotted mask, lowest
// first, driving the result-mux select and streaming one registered beat per
// free output slot. The select is only moved when a new lane is needed, so
// the mux stays quiet while idle or stalled.
module mux32_readout_sched
  import sysarr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mux32_readout_sched_if.master bus
);

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;

  logic [LANE_W-1:0]   r_sel;
  logic [LANES-1:0]    r_pend;
  logic [DATA_W-1:0]   r_out_data;
  logic [LANE_W-1:0]   r_out_lane;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;

  logic [LANE_W-1:0]   w_first_idx;
  logic                w_first_any;
  logic [LANES-1:0]    w_pend_rest;
  logic [LANE_W-1:0]   w_next_idx;
  logic                w_next_any;
  logic                w_slot_free;

  logic                w_load;
  logic                w_capture;
  logic                w_release;
  logic                w_done_set;

  // Pending lanes once the currently selected lane has been taken.
  assign w_pend_rest = r_pend & ~(LANES'(1) << r_sel);
  assign w_slot_free = !r_out_valid || bus.out_ready;

  lane_pick_first u_pick_first (
    .vec (bus.lane_mask),
    .idx (w_first_idx),
    .any (w_first_any)
  );

  lane_pick_first u_pick_next (
    .vec (w_pend_rest),
    .idx (w_next_idx),
    .any (w_next_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (bus.start && w_first_any)        w_state_nxt = SCAN;
      SCAN:  if (w_slot_free && !w_next_any)      w_state_nxt = DRAIN;
      DRAIN: if (r_out_valid && bus.out_ready)    w_state_nxt = IDLE;
      default:                                    w_state_nxt = IDLE;
    endcase
  end

  // Control strobes for the datapath, decoded from the current state.
  always_comb begin
    w_load     = 1'b0;
    w_capture  = 1'b0;
    w_release  = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_load     = bus.start;
        w_done_set = bus.start && !w_first_any;
      end
      SCAN:  w_capture = w_slot_free;
      DRAIN: begin
        w_release  = r_out_valid && bus.out_ready;
        w_done_set = r_out_valid && bus.out_ready;
      end
      default: ;
    endcase
  end

  // Select, pending mask, output beat registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= '0;
      r_pend      <= '0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_busy <= (w_state_nxt != IDLE);

      if (w_load) begin
        r_pend <= bus.lane_mask;
        // An empty mask leaves the select where it was.
        if (w_first_any) r_sel <= w_first_idx;
      end

      if (w_capture) begin
        r_out_data  <= bus.mux_y;
        r_out_lane  <= r_sel;
        r_out_valid <= 1'b1;
        r_out_last  <= !w_next_any;
        r_pend      <= w_pend_rest;
        if (w_next_any) r_sel <= w_next_idx;
      end

      if (w_release) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign bus.sel       = {{(SEL_W - LANE_W){1'b0}}, r_sel};
  assign bus.out_data  = r_out_data;
  assign bus.out_lane  = r_out_lane;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_mux32_readout_sched.sv
// Directed bench for the readout scheduler. The array mux is modelled as
// lane index + 100, so every expected beat value is known in advance.
`timescale 1ns/1ps
module tb_mux32_readout_sched;
  import sysarr_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux32_readout_sched_if bus ();

  mux32_readout_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Array result mux model: lane i presents i + 100.
  assign bus.mux_y = DATA_W'(bus.sel) + DATA_W'(100);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " sel"},       32'(bus.sel),       32'd0);
    check({tag, " out_data"},  32'(bus.out_data),  32'd0);
    check({tag, " out_lane"},  32'(bus.out_lane),  32'd0);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " out_last"},  32'(bus.out_last),  32'd0);
    check({tag, " busy"},      32'(bus.busy),      32'd0);
    check({tag, " done"},      32'(bus.done),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] lanes3 [3];
    logic [4:0] sels3  [3];
    checks   = 0;
    failures = 0;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.lane_mask = '0;
    bus.out_ready = 1'b1;
    #1;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check_reset_values("idle after reset");

    // Full mask, ready held high: 32 back-to-back beats.
    bus.start     = 1'b1;
    bus.lane_mask = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    check("full sel first",  32'(bus.sel),       32'd0);
    check("full busy",       32'(bus.busy),      32'd1);
    check("full no beat yet",32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("full valid %0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("full lane %0d", i),  32'(bus.out_lane),  32'(i));
      check($sformatf("full data %0d", i),  32'(bus.out_data),  32'(100 + i));
      check($sformatf("full last %0d", i),  32'(bus.out_last),  (i == 31) ? 32'd1 : 32'd0);
      check($sformatf("full done %0d", i),  32'(bus.done),      32'd0);
    end
    tick();
    check("full done pulse",  32'(bus.done),      32'd1);
    check("full valid clear", 32'(bus.out_valid), 32'd0);
    check("full busy clear",  32'(bus.busy),      32'd0);
    check("full sel holds",   32'(bus.sel),       32'd31);
    tick();
    check("full done once",   32'(bus.done),      32'd0);

    // Sparse mask: lanes 0, 4, 31 only; select only ever lands on them.
    lanes3 = '{5'd0, 5'd4, 5'd31};
    sels3  = '{5'd4, 5'd31, 5'd31};
    bus.start     = 1'b1;
    bus.lane_mask = 32'h8000_0011;
    tick();
    bus.start = 1'b0;
    check("sparse sel first", 32'(bus.sel), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sparse lane %0d", i), 32'(bus.out_lane), 32'(lanes3[i]));
      check($sformatf("sparse data %0d", i), 32'(bus.out_data), 32'(lanes3[i]) + 32'd100);
      check($sformatf("sparse last %0d", i), 32'(bus.out_last), (i == 2) ? 32'd1 : 32'd0);
      check($sformatf("sparse sel %0d", i),  32'(bus.sel),      32'(sels3[i]));
    end
    tick();
    check("sparse done",  32'(bus.done),      32'd1);
    check("sparse valid", 32'(bus.out_valid), 32'd0);
    tick();

    // Empty mask: done next cycle, no beats, never busy, select untouched.
    bus.start     = 1'b1;
    bus.lane_mask = 32'h0;
    tick();
    bus.start = 1'b0;
    check("empty done",  32'(bus.done),      32'd1);
    check("empty valid", 32'(bus.out_valid), 32'd0);
    check("empty busy",  32'(bus.busy),      32'd0);
    check("empty sel",   32'(bus.sel),       32'd31);
    tick();
    check("empty done once", 32'(bus.done),      32'd0);
    check("empty valid 2",   32'(bus.out_valid), 32'd0);
    check("empty busy 2",    32'(bus.busy),      32'd0);

    // Mask 0xF with a 3-cycle stall on the lane-1 beat.
    bus.start     = 1'b1;
    bus.lane_mask = 32'h0000_000F;
    tick();
    bus.start = 1'b0;
    check("stall sel first", 32'(bus.sel), 32'd0);
    tick();
    check("stall lane0", 32'(bus.out_lane), 32'd0);
    tick();
    check("stall lane1",      32'(bus.out_lane), 32'd1);
    check("stall lane1 data", 32'(bus.out_data), 32'd101);
    check("stall lane1 sel",  32'(bus.sel),      32'd2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall hold valid %0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall hold lane %0d", i),  32'(bus.out_lane),  32'd1);
      check($sformatf("stall hold data %0d", i),  32'(bus.out_data),  32'd101);
      check($sformatf("stall hold sel %0d", i),   32'(bus.sel),       32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    check("stall lane2",      32'(bus.out_lane), 32'd2);
    check("stall lane2 data", 32'(bus.out_data), 32'd102);
    check("stall lane2 last", 32'(bus.out_last), 32'd0);
    tick();
    check("stall lane3",      32'(bus.out_lane), 32'd3);
    check("stall lane3 data", 32'(bus.out_data), 32'd103);
    check("stall lane3 last", 32'(bus.out_last), 32'd1);
    tick();
    check("stall done",  32'(bus.done),      32'd1);
    check("stall valid", 32'(bus.out_valid), 32'd0);
    tick();

    // Reset while lane 5 of 0xFF is still pending.
    bus.start     = 1'b1;
    bus.lane_mask = 32'h0000_00FF;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("abort mid lane", 32'(bus.out_lane), 32'd2);
    rst = 1'b1;
    tick();
    check_reset_values("abort reset");
    rst = 1'b0;
    tick();
    check("abort no done", 32'(bus.done),      32'd0);
    check("abort idle",    32'(bus.busy),      32'd0);
    check("abort no beat", 32'(bus.out_valid), 32'd0);
    bus.start     = 1'b1;
    bus.lane_mask = 32'h0000_0001;
    tick();
    bus.start = 1'b0;
    check("single sel",  32'(bus.sel),  32'd0);
    check("single busy", 32'(bus.busy), 32'd1);
    tick();
    check("single valid", 32'(bus.out_valid), 32'd1);
    check("single lane",  32'(bus.out_lane),  32'd0);
    check("single data",  32'(bus.out_data),  32'd100);
    check("single last",  32'(bus.out_last),  32'd1);
    tick();
    check("single done",  32'(bus.done),      32'd1);
    check("single clear", 32'(bus.out_valid), 32'd0);
    tick();

    // Start re-asserted mid-pass with another mask is ignored.
    bus.start     = 1'b1;
    bus.lane_mask = 32'h0000_0124;
    tick();
    bus.lane_mask = 32'h0000_0003;
    check("restart sel first", 32'(bus.sel), 32'd2);
    tick();
    check("restart lane a", 32'(bus.out_lane), 32'd2);
    check("restart sel a",  32'(bus.sel),      32'd5);
    tick();
    check("restart lane b", 32'(bus.out_lane), 32'd5);
    check("restart sel b",  32'(bus.sel),      32'd8);
    tick();
    check("restart lane c", 32'(bus.out_lane), 32'd8);
    check("restart data c", 32'(bus.out_data), 32'd108);
    check("restart last c", 32'(bus.out_last), 32'd1);
    tick();
    bus.start = 1'b0;
    check("restart done",  32'(bus.done),      32'd1);
    check("restart valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("restart idle",  32'(bus.busy),      32'd0);
    check("restart quiet", 32'(bus.out_valid), 32'd0);
    check("restart sel",   32'(bus.sel),       32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
